// File: rtl/odelay_pkg.sv
// odelay_pkg: mode encodings, tap-index type and configuration check shared
// by odelay_bank and odelay_chan.
package odelay_pkg;

    typedef enum logic [1:0] {
        ODELAY_FIXED    = 2'd0,
        ODELAY_VARIABLE = 2'd1,
        ODELAY_VAR_LOAD = 2'd2
    } odelay_mode_e;

    // Tap index at the default line width (32 taps).
    localparam int TAP_W_DEFAULT = 5;
    typedef logic [TAP_W_DEFAULT-1:0] tap_idx_t;

    // True when the mode is known and the initial tap fits inside the line.
    function automatic bit cfg_ok(int mode, int value, int tap_w);
        return (mode >= 0) && (mode <= int'(ODELAY_VAR_LOAD)) &&
               (value >= 0) && (value < (1 << tap_w));
    endfunction

endpackage

// File: rtl/odelay_chan.sv
// odelay_chan: one delay channel. It holds a (2**TAP_W)-1 stage shift line,
// a registered tap mux, the tap counter and, when ODELAY_BANK_PIPE_EN is
// defined, a pipeline register that feeds the VAR_LOAD load path.
module odelay_chan
    import odelay_pkg::*;
#(
    parameter int TAP_W        = 5,
    parameter int ODELAY_TYPE  = 0,
    parameter int ODELAY_VALUE = 0,
    parameter int DATA_INV     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             odatain,
    input  logic             ce,
    input  logic             inc,
    input  logic             ld,
    input  logic             ldpipeen,
    input  logic             regrst,
    input  logic [TAP_W-1:0] cntvaluein,
    output logic             dataout,
    output logic [TAP_W-1:0] cntvalueout
);

    localparam int               DEPTH       = 1 << TAP_W;
    localparam logic [TAP_W-1:0] TAP_INIT    = TAP_W'(ODELAY_VALUE);
    localparam bit               IS_FIXED    = (ODELAY_TYPE == int'(ODELAY_FIXED));
    localparam bit               IS_VAR_LOAD = (ODELAY_TYPE == int'(ODELAY_VAR_LOAD));
    localparam logic             INV         = (DATA_INV != 0);

    logic             din;
    logic [DEPTH-2:0] line_q;
    logic [DEPTH-1:0] taps;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] load_src;

    // Tap t selects the sample that entered t edges ago; tap 0 is the live input.
    assign din         = odatain ^ INV;
    assign taps        = {line_q, din};
    assign cntvalueout = tap_q;

`ifdef ODELAY_BANK_PIPE_EN
    logic [TAP_W-1:0] pipe_q;

    // Pipeline register for the load value; clear has priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (run && !IS_FIXED) begin
            if (regrst) begin
                pipe_q <= '0;
            end else if (ldpipeen) begin
                pipe_q <= cntvaluein;
            end
        end
    end

    assign load_src = pipe_q;
`else
    logic unused_pipe_ctrl;

    assign unused_pipe_ctrl = ldpipeen ^ regrst;
    assign load_src         = cntvaluein;
`endif

    // Shift line and registered output mux; the mux uses the tap held during
    // this cycle, so a counter change shows up on the next output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            dataout <= 1'b0;
        end else if (run) begin
            line_q  <= taps[DEPTH-2:0];
            dataout <= taps[tap_q];
        end
    end

    // Tap counter: load beats step; steps wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= TAP_INIT;
        end else if (run && !IS_FIXED) begin
            if (ld) begin
                tap_q <= IS_VAR_LOAD ? load_src : TAP_INIT;
            end else if (ce) begin
                tap_q <= inc ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
            end
        end
    end

endmodule

// File: rtl/odelay_bank.sv
// odelay_bank: NCH independent tap-delay channels sharing one clock and an
// asynchronous active-low reset whose release is synchronised here.
// Optional feature macro: ODELAY_BANK_PIPE_EN adds a per-channel pipeline
// register as the VAR_LOAD load source.
module odelay_bank
    import odelay_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int TAP_W        = 5,
    parameter int ODELAY_TYPE  = 0,
    parameter int ODELAY_VALUE = 0,
    parameter int DATA_INV     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       odatain,
    input  logic [NCH-1:0]       ce,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH-1:0]       ldpipeen,
    input  logic [NCH-1:0]       regrst,
    input  logic [NCH*TAP_W-1:0] cntvaluein,
    output logic [NCH-1:0]       dataout,
    output logic [NCH*TAP_W-1:0] cntvalueout
);

    generate
        if (!cfg_ok(ODELAY_TYPE, ODELAY_VALUE, TAP_W)) begin : g_bad_cfg
            $error("odelay_bank: ODELAY_TYPE must be 0..2 and ODELAY_VALUE below 2**TAP_W");
        end
    endgenerate

    logic run_q;

    // Release enable: the first edge after reset only arms run_q, so channel
    // state first moves on the second edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        odelay_chan #(
            .TAP_W        (TAP_W),
            .ODELAY_TYPE  (ODELAY_TYPE),
            .ODELAY_VALUE (ODELAY_VALUE),
            .DATA_INV     (DATA_INV)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .run         (run_q),
            .odatain     (odatain[k]),
            .ce          (ce[k]),
            .inc         (inc[k]),
            .ld          (ld[k]),
            .ldpipeen    (ldpipeen[k]),
            .regrst      (regrst[k]),
            .cntvaluein  (cntvaluein[k*TAP_W +: TAP_W]),
            .dataout     (dataout[k]),
            .cntvalueout (cntvalueout[k*TAP_W +: TAP_W])
        );
    end

endmodule
